// File: rtl/ac_motor_deadtime.sv
// Dead-time insertion and shoot-through guard for one half-bridge leg.
// Gate and status outputs are registered and decoded from the next state.
module ac_motor_deadtime #(
  parameter int DEAD_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic pwm_hi,
  input  logic pwm_lo,
  input  logic fault_clr,
  output logic gate_hi,
  output logic gate_lo,
  output logic dead_active,
  output logic fault
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DEAD,
    S_HI,
    S_LO,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             shoot;

  assign shoot = pwm_hi & pwm_lo;

  // Shoot-through beats everything, and a latched fault ignores enable.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (shoot) begin
      state_nxt = S_FAULT;
    end else if (state == S_FAULT) begin
      if (fault_clr) state_nxt = S_OFF;
    end else if (!enable) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF: begin
          if (pwm_hi ^ pwm_lo) begin
            state_nxt = S_DEAD;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        S_DEAD: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (pwm_hi) begin
            state_nxt = S_HI;
          end else if (pwm_lo) begin
            state_nxt = S_LO;
          end else begin
            state_nxt = S_OFF;
          end
        end
        S_HI: begin
          if (!pwm_hi) begin
            state_nxt = S_DEAD;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        S_LO: begin
          if (!pwm_lo) begin
            state_nxt = S_DEAD;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_OFF;
      cnt         <= '0;
      gate_hi     <= 1'b0;
      gate_lo     <= 1'b0;
      dead_active <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      gate_hi     <= (state_nxt == S_HI);
      gate_lo     <= (state_nxt == S_LO);
      dead_active <= (state_nxt == S_DEAD);
      fault       <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_ac_motor_deadtime.sv
// Scoreboard bench for ac_motor_deadtime: a behavioural leg model queues the
// expected outputs per edge, and a monitor compares them after each clock edge.
module tb_ac_motor_deadtime;

  localparam int DEAD = 4;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic pwm_hi;
  logic pwm_lo;
  logic fault_clr;
  logic gate_hi;
  logic gate_lo;
  logic dead_active;
  logic fault;

  ac_motor_deadtime #(.DEAD_CYCLES(DEAD), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pwm_hi(pwm_hi),
    .pwm_lo(pwm_lo),
    .fault_clr(fault_clr),
    .gate_hi(gate_hi),
    .gate_lo(gate_lo),
    .dead_active(dead_active),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic gh;
    logic gl;
    logic da;
    logic f;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: which side is conducting, how many dead cycles remain, fault latch.
  int side      = 0;   // 0 none, 1 high, 2 low
  int dead_left = 0;
  bit faulted   = 1'b0;

  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic hi_v,
                               input logic lo_v, input logic clr_v);
    exp_t e;
    @(negedge clk);
    reset     = rst_v;
    enable    = en_v;
    pwm_hi    = hi_v;
    pwm_lo    = lo_v;
    fault_clr = clr_v;
    if (rst_v) begin
      side = 0; dead_left = 0; faulted = 1'b0;
    end else if (hi_v && lo_v) begin
      side = 0; dead_left = 0; faulted = 1'b1;
    end else if (faulted) begin
      if (clr_v) faulted = 1'b0;
    end else if (!en_v) begin
      side = 0; dead_left = 0;
    end else if (dead_left > 0) begin
      dead_left = dead_left - 1;
      if (dead_left == 0) side = hi_v ? 1 : (lo_v ? 2 : 0);
    end else if ((side == 1 && !hi_v) || (side == 2 && !lo_v)) begin
      side = 0; dead_left = DEAD;
    end else if (side == 0 && (hi_v ^ lo_v)) begin
      dead_left = DEAD;
    end
    e.gh = (side == 1);
    e.gl = (side == 2);
    e.da = (dead_left > 0);
    e.f  = faulted;
    sb.push_back(e);
  endtask

  logic prev_hi = 1'b0;
  logic prev_lo = 1'b0;
  int   low_run = 0;

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if ({gate_hi, gate_lo, dead_active, fault} !== {e.gh, e.gl, e.da, e.f}) begin
      n_bad++;
      $display("[TB] FAIL outputs t=%0t got hi/lo/dead/fault=%b%b%b%b want %b%b%b%b",
               $time, gate_hi, gate_lo, dead_active, fault, e.gh, e.gl, e.da, e.f);
    end
    n_vec++;
    if ((gate_hi & gate_lo) !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL both_gates t=%0t got %b want 0", $time, gate_hi & gate_lo);
    end
    if ((gate_hi && !prev_hi) || (gate_lo && !prev_lo)) begin
      n_vec++;
      if (low_run < DEAD) begin
        n_bad++;
        $display("[TB] FAIL dead_gap t=%0t got %0d low cycles want >=%0d", $time, low_run, DEAD);
      end
    end
    low_run = (!gate_hi && !gate_lo) ? low_run + 1 : 0;
    prev_hi = gate_hi;
    prev_lo = gate_lo;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic en_v, hi_v, lo_v, clr_v, rst_v;
    int   kind, len;
    real  tri_r, sine_r;
    int   ph;

    reset = 1'b1; enable = 1'b1; pwm_hi = 1'b1; pwm_lo = 1'b0; fault_clr = 1'b0;

    // Turn-on from reset still owes a full dead time.
    repeat (2) applyStimulus(1, 1, 1, 0, 0);
    repeat (8) applyStimulus(0, 1, 1, 0, 0);
    // Direct swap high -> low.
    repeat (8) applyStimulus(0, 1, 0, 1, 0);
    // Short high pulse from LO is swallowed.
    repeat (2) applyStimulus(0, 1, 1, 0, 0);
    repeat (6) applyStimulus(0, 1, 0, 0, 0);
    // Shoot-through from HI, clear blocked while both demands stay up.
    repeat (6) applyStimulus(0, 1, 1, 0, 0);
    repeat (2) applyStimulus(0, 1, 1, 1, 0);
    repeat (2) applyStimulus(0, 1, 1, 1, 1);
    applyStimulus(0, 1, 0, 0, 1);
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    // Enable drop in LO, then re-enable.
    repeat (6) applyStimulus(0, 1, 0, 1, 0);
    repeat (2) applyStimulus(0, 0, 0, 1, 0);
    repeat (7) applyStimulus(0, 1, 0, 1, 0);
    // Fault latched with enable low stays latched.
    repeat (2) applyStimulus(0, 0, 1, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 1);

    // Sine-triangle comparator drive for 2500 time units.
    for (int i = 0; i < 250; i++) begin
      ph     = i % 40;
      tri_r  = ((ph < 20) ? ph : 40 - ph) / 10.0 - 1.0;
      sine_r = 0.9 * $sin(2.0 * 3.14159265 * i / 250.0);
      hi_v   = (sine_r > tri_r);
      applyStimulus(0, 1, hi_v, !hi_v, 0);
    end

    // Randomized demand segments with enable drops, faults, clears and resets.
    for (int s = 0; s < 120; s++) begin
      kind  = $urandom_range(0, 19);
      len   = $urandom_range(1, 10);
      en_v  = 1'b1; hi_v = 1'b0; lo_v = 1'b0; rst_v = 1'b0;
      clr_v = ($urandom_range(0, 3) == 0);
      if (kind < 8) hi_v = 1'b1;
      else if (kind < 16) lo_v = 1'b1;
      else if (kind == 16) en_v = 1'b0;
      else if (kind == 17) begin hi_v = 1'b1; lo_v = 1'b1; len = $urandom_range(1, 2); end
      else if (kind == 18) begin rst_v = 1'b1; hi_v = 1'b1; len = 1; end
      for (int j = 0; j < len; j++) applyStimulus(rst_v, en_v, hi_v, lo_v, clr_v);
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
